// File: rtl/alu_seq_controller.sv
// alu_seq_controller: debounced three-button operand/opcode capture driving a registered ALU with flags
// Ports: i_clock clock; i_reset sync active-low reset; i_switches operand/opcode source;
//        i_pulsadores raw buttons (bit0 load A, bit1 load B, bit2 load op);
//        o_result/o_zero/o_carry/o_overflow registered ALU outputs; o_valid held result valid;
//        o_error sticky sequence/opcode error; o_state FSM code.
// Optional: define ALU_CHAIN_EN to allow pulse2 in S_DONE to reload A from o_result and re-execute.
module alu_seq_controller #(
  parameter int NB_DATA = 8,
  parameter int NB_OPCODE = 6,
  parameter int N_PULSADORES = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_DATA-1:0]      i_switches,
  input  logic [N_PULSADORES-1:0] i_pulsadores,
  output logic [NB_DATA-1:0]      o_result,
  output logic                    o_valid,
  output logic                    o_zero,
  output logic                    o_carry,
  output logic                    o_overflow,
  output logic                    o_error,
  output logic [2:0]              o_state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int M = NB_DATA - 1;
  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
  localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
  localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
`ifdef ALU_CHAIN_EN
  localparam logic [2:0] DONE_MASK = 3'b101;
`else
  localparam logic [2:0] DONE_MASK = 3'b001;
`endif
  typedef enum logic [2:0] {S_A = 3'd0, S_B = 3'd1, S_OP = 3'd2, S_EXEC = 3'd3, S_DONE = 3'd4} state_t;
  state_t state;
  logic [2:0] s1, s2, pulse, exp_mask;
  logic [NB_DATA-1:0] a, b, alu_r;
  logic [NB_OPCODE-1:0] op;
  logic [NB_DATA:0] sum, dif;
  logic alu_c, alu_v, alu_bad;
  logic unused_btn;
  assign unused_btn = ^i_pulsadores;
  assign o_state = state;
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_pulsadores[2:0];
      s2 <= s1;
    end
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic [CW-1:0] cnt;
    logic d, p;
    assign pulse[g] = p;
    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples; the
    // rising flip is also registered as the one-cycle pulse.
    always_ff @(posedge i_clock)
      if (!i_reset) begin
        cnt <= '0;
        d <= 1'b0;
        p <= 1'b0;
      end else begin
        p <= 1'b0;
        if (s2[g] == d) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          d <= ~d;
          p <= ~d;
        end else cnt <= cnt + 1'b1;
      end
  end
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb
    exp_mask = state == S_A ? 3'b001 : state == S_B ? 3'b010 : state == S_OP ? 3'b100 :
               state == S_DONE ? DONE_MASK : 3'b000;
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_bad = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = sum[M:0];
        alu_c = sum[NB_DATA];
        alu_v = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        alu_r = dif[M:0];
        alu_c = dif[NB_DATA];
        alu_v = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_NOR: alu_r = ~(a | b);
      // Shift amounts of NB_DATA or more saturate to all-sign / all-zero by operator semantics.
      OP_SRA: alu_r = $signed(a) >>> b;
      OP_SRL: alu_r = a >> b;
      default: alu_bad = 1'b1;
    endcase
  end
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      state <= S_A;
      a <= '0;
      b <= '0;
      op <= '0;
      o_result <= '0;
      o_valid <= 1'b0;
      o_zero <= 1'b0;
      o_carry <= 1'b0;
      o_overflow <= 1'b0;
      o_error <= 1'b0;
    end else begin
      case (state)
        S_A: if (pulse[0]) begin
          a <= i_switches;
          o_error <= 1'b0;
          state <= S_B;
        end
        S_B: if (pulse[1]) begin
          b <= i_switches;
          state <= S_OP;
        end
        S_OP: if (pulse[2]) begin
          op <= i_switches[NB_OPCODE-1:0];
          state <= S_EXEC;
        end
        S_EXEC: begin
          o_result <= alu_r;
          o_zero <= alu_r == '0;
          o_carry <= alu_c;
          o_overflow <= alu_v;
          o_valid <= 1'b1;
          if (alu_bad) o_error <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: if (pulse[0]) begin
          a <= i_switches;
          o_error <= 1'b0;
          o_valid <= 1'b0;
          state <= S_B;
        end
`ifdef ALU_CHAIN_EN
        else if (pulse[2]) begin
          a <= o_result;
          op <= i_switches[NB_OPCODE-1:0];
          state <= S_EXEC;
        end
`endif
        default: state <= S_A;
      endcase
      // Placed last so an out-of-order pulse wins over the clear done by a simultaneous pulse0.
      if (|(pulse & ~exp_mask)) o_error <= 1'b1;
    end
endmodule

// File: tb/tb_alu_seq_controller.sv
// tb_alu_seq_controller: scoreboard bench for the debounced ALU sequence controller
module tb_alu_seq_controller;
  localparam int D = 4;
  localparam logic [7:0] ADD = 8'h20, SUB = 8'h22, AND_ = 8'h24, OR_ = 8'h25, XOR_ = 8'h26,
                         NOR_ = 8'h27, SRA = 8'h03, SRL = 8'h02;
  typedef struct packed {logic [7:0] r; logic z, c, v, e;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] sw;
  logic [2:0] btn;
  logic [7:0] result;
  logic valid, zero, carry, ovf, err;
  logic [2:0] state;
  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  alu_seq_controller #(.NB_DATA(8), .NB_OPCODE(6), .N_PULSADORES(3), .DEBOUNCE_CYCLES(D)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_switches(sw), .i_pulsadores(btn),
    .o_result(result), .o_valid(valid), .o_zero(zero), .o_carry(carry),
    .o_overflow(ovf), .o_error(err), .o_state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    exp_t m;
    int sa, sb, t;
    sa = a > 127 ? int'(a) - 256 : int'(a);
    sb = b > 127 ? int'(b) - 256 : int'(b);
    m = '0;
    case (op)
      6'h20: begin t = int'(a) + int'(b); m.r = t[7:0]; m.c = t > 255; m.v = (sa + sb > 127) || (sa + sb < -128); end
      6'h22: begin t = int'(a) - int'(b); m.r = t[7:0]; m.c = a < b; m.v = (sa - sb > 127) || (sa - sb < -128); end
      6'h24: m.r = a & b;
      6'h25: m.r = a | b;
      6'h26: m.r = a ^ b;
      6'h27: m.r = ~(a | b);
      6'h03: begin t = b >= 8 ? (sa < 0 ? -1 : 0) : sa >>> b; m.r = t[7:0]; end
      6'h02: begin t = b >= 8 ? 0 : int'(a) >> b; m.r = t[7:0]; end
      default: m.e = 1'b1;
    endcase
    m.z = m.r == 8'h00;
    return m;
  endfunction

  task automatic push_exp(input logic [7:0] r, input logic c, input logic v, input logic e);
    exp_t m;
    m.r = r; m.z = r == 8'h00; m.c = c; m.v = v; m.e = e;
    q.push_back(m);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    btn = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic btn_down(input int k);
    @(negedge clk);
    btn[k] = 1'b1;
  endtask

  task automatic btn_up(input int k);
    repeat (D + 4) @(negedge clk);
    btn[k] = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic press(input int k);
    btn_down(k);
    btn_up(k);
  endtask

  // Waits for the one-cycle S_EXEC state, then pops the oldest expectation and compares the registered outputs.
  task automatic await_result(input string name);
    exp_t e;
    int n = 0;
    while (state !== 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = q.pop_front();
    if (n >= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: timeout waiting for S_EXEC, state=%0d", name, state);
      return;
    end
    @(negedge clk);
    n_cmp++; if (result !== e.r) begin n_fail++; $display("FAIL %s result: got %h want %h", name, result, e.r); end
    n_cmp++; if (zero !== e.z) begin n_fail++; $display("FAIL %s zero: got %b want %b", name, zero, e.z); end
    n_cmp++; if (carry !== e.c) begin n_fail++; $display("FAIL %s carry: got %b want %b", name, carry, e.c); end
    n_cmp++; if (ovf !== e.v) begin n_fail++; $display("FAIL %s overflow: got %b want %b", name, ovf, e.v); end
    n_cmp++; if (err !== e.e) begin n_fail++; $display("FAIL %s error: got %b want %b", name, err, e.e); end
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL %s valid: got %b want 1", name, valid); end
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL %s state: got %0d want 4", name, state); end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input string name, input logic use_model);
    sw = a; press(0);
    sw = b; press(1);
    sw = op;
    if (use_model) q.push_back(model(a, b, op[5:0]));
    btn_down(2);
    await_result(name);
    btn_up(2);
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset result: got %h want 00", result); end
    n_cmp++; if ({valid, zero, carry, ovf, err} !== 5'b0) begin n_fail++; $display("FAIL reset flags: got %b want 00000", {valid, zero, carry, ovf, err}); end
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset state: got %0d want 0", state); end
  endtask

  task automatic test_add();
    int n = 0;
    sw = 8'h05;
    @(negedge clk);
    btn[0] = 1'b1;
    // The pulse appears 2+D edges after the press; the FSM reflects it on the following edge.
    do begin
      @(posedge clk); #1;
      n++;
    end while (state === 3'd0 && n < 20);
    n_cmp++; if (n != D + 3) begin n_fail++; $display("FAIL press latency: got %0d edges want %0d", n, D + 3); end
    btn_up(0);
    sw = 8'h03; press(1);
    sw = ADD;
    push_exp(8'h08, 1'b0, 1'b0, 1'b0);
    btn_down(2);
    n = 0;
    while (state !== 3'd3 && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL add valid early: got %b want 0", valid); end
    await_result("add_5_3");
    btn_up(2);
  endtask

  task automatic test_arith();
    push_exp(8'h00, 1'b1, 1'b1, 1'b0); run_op(8'h80, 8'h80, ADD, "add_80_80", 1'b0);
    push_exp(8'hFE, 1'b1, 1'b0, 1'b0); run_op(8'h03, 8'h05, SUB, "sub_3_5", 1'b0);
    push_exp(8'hF3, 1'b0, 1'b0, 1'b0); run_op(8'hCC, 8'h02, SRA, "sra_cc_2", 1'b0);
    push_exp(8'h00, 1'b0, 1'b0, 1'b0); run_op(8'hCC, 8'h09, SRL, "srl_cc_9", 1'b0);
    push_exp(8'hFF, 1'b0, 1'b0, 1'b0); run_op(8'hCC, 8'h09, SRA, "sra_cc_9", 1'b0);
    run_op(8'h7F, 8'h01, ADD, "add_ovf", 1'b1);
    run_op(8'h80, 8'h01, SUB, "sub_ovf", 1'b1);
    run_op(8'hA5, 8'h3C, AND_, "and", 1'b1);
    run_op(8'hA5, 8'h3C, OR_, "or", 1'b1);
    run_op(8'hA5, 8'h3C, XOR_, "xor", 1'b1);
    run_op(8'hA5, 8'h3C, NOR_, "nor", 1'b1);
    run_op(8'h81, 8'h03, SRL, "srl_81_3", 1'b1);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_op(a, b, i == 0 ? ADD : SUB, "rand", 1'b1);
    end
    push_exp(8'h00, 1'b0, 1'b0, 1'b1); run_op(8'h12, 8'h34, 8'h3F, "undef_op", 1'b0);
  endtask

  task automatic test_glitch();
    reset_dut();
    sw = 8'h55;
    @(negedge clk);
    btn[0] = 1'b1;
    repeat (D - 1) @(negedge clk);
    btn[0] = 1'b0;
    repeat (3 * D) @(negedge clk);
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL glitch state: got %0d want 0", state); end
    press(2);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL early op error: got %b want 1", err); end
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL early op state: got %0d want 0", state); end
    press(0);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL error clear: got %b want 0", err); end
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL load A state: got %0d want 1", state); end
    press(2);
    n_cmp++; if (err !== 1'b1 || state !== 3'd1) begin n_fail++; $display("FAIL op in S_B: got err=%b state=%0d want err=1 state=1", err, state); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_dut();
    run_op(8'h12, 8'h34, ADD, "pre_reset", 1'b1);
    sw = 8'h11; press(0);
    sw = 8'h22; press(1);
    n_cmp++; if (state !== 3'd2 || result !== 8'h46) begin n_fail++; $display("FAIL S_OP held: got state=%0d result=%h want 2/46", state, result); end
    @(negedge clk);
    rst_n = 1'b0;
    btn[0] = 1'b1;
    sw = 8'h21;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if ({result, valid, zero, carry, ovf, err, state} !== 16'h0) begin n_fail++; $display("FAIL mid reset: got result=%h flags=%b state=%0d want all 0", result, {valid, zero, carry, ovf, err}, state); end
    while (state !== 3'd1 && n < 30) begin @(negedge clk); n++; end
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL held button load: got state %0d want 1", state); end
    repeat (20) @(negedge clk);
    n_cmp++; if (state !== 3'd1 || err !== 1'b0) begin n_fail++; $display("FAIL held button single pulse: got state=%0d err=%b want 1/0", state, err); end
    btn[0] = 1'b0;
    repeat (D + 4) @(negedge clk);
    sw = 8'h10; press(1);
    sw = ADD;
    push_exp(8'h31, 1'b0, 1'b0, 1'b0);
    btn_down(2);
    await_result("held_a_plus_b");
    btn_up(2);
  endtask

  task automatic test_chain();
    reset_dut();
    run_op(8'h05, 8'h03, ADD, "chain_base", 1'b1);
    sw = ADD;
`ifdef ALU_CHAIN_EN
    push_exp(8'h0B, 1'b0, 1'b0, 1'b0);
    btn_down(2);
    await_result("chain_add");
    btn_up(2);
`else
    press(2);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL chain disabled error: got %b want 1", err); end
    n_cmp++; if (result !== 8'h08 || state !== 3'd4 || valid !== 1'b1) begin n_fail++; $display("FAIL chain disabled hold: got result=%h state=%0d valid=%b want 08/4/1", result, state, valid); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    btn = '0;
    sw = '0;
    test_reset();
    test_add();
    test_arith();
    test_glitch();
    test_reset_mid();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
